// File: rtl/axis_timing_scheduler_if.sv
// Engine-side bus of the axis timing scheduler: launch data out, per-axis result words back.
interface axis_timing_scheduler_if #(
    parameter int unsigned W  = 32,
    parameter int unsigned NP = 5
);
    logic              eng_start;
    logic              eng_const_speed;
    logic [W-1:0]      eng_num;
    logic [W-1:0]      eng_speed;
    logic [W-1:0]      eng_acc;
    logic [W-1:0]      eng_jerk;
    logic [NP*W-1:0]   eng_params;
    logic              eng_finish;

    modport master (
        output eng_start, eng_const_speed, eng_num, eng_speed, eng_acc, eng_jerk,
        input  eng_params, eng_finish
    );

    modport slave (
        input  eng_start, eng_const_speed, eng_num, eng_speed, eng_acc, eng_jerk,
        output eng_params, eng_finish
    );
endinterface

// File: rtl/axis_timing_scheduler.sv
// Time-multiplexes one speed_to_timing engine across N_AXES axes, collecting
// each axis result into a per-axis parameter bank with valid/err flags.
module axis_timing_scheduler #(
    parameter int unsigned N_AXES    = 5,
    parameter int unsigned W         = 32,
    parameter int unsigned NP        = 5,
    parameter int unsigned GAP       = 20,
    parameter int unsigned TIMEOUT   = 1000000,
    parameter int unsigned SKIP_ZERO = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     const_speed,
    input  logic [N_AXES*W-1:0]      num,
    input  logic [N_AXES*W-1:0]      speed,
    input  logic [N_AXES*W-1:0]      acceleration,
    input  logic [N_AXES*W-1:0]      jerk,
    output logic                     busy,
    output logic                     done,
    output logic                     finish,
    output logic [N_AXES*NP*W-1:0]   params,
    output logic [N_AXES-1:0]        valid,
    output logic [N_AXES-1:0]        err,
    axis_timing_scheduler_if.master  eng
);
    localparam int unsigned IW  = (N_AXES > 1) ? $clog2(N_AXES) : 1;
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);
    localparam int unsigned BW  = NP * W;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_GAP, S_DONE} state_t;

    state_t                 state, state_d;
    logic [IW-1:0]          idx, idx_d;
    logic [15:0]            gap_cnt, gap_cnt_d;
    logic [WDW-1:0]         wd, wd_d;
    logic                   snap_cs, snap_cs_d;
    logic [N_AXES*W-1:0]    snap_num, snap_num_d;
    logic [N_AXES*W-1:0]    snap_spd, snap_spd_d;
    logic [N_AXES*W-1:0]    snap_acc, snap_acc_d;
    logic [N_AXES*W-1:0]    snap_jrk, snap_jrk_d;
    logic                   busy_d, done_d, finish_d;
    logic [N_AXES*NP*W-1:0] params_d;
    logic [N_AXES-1:0]      valid_d, err_d;
    logic                   eng_start_d, eng_cs_d;
    logic [W-1:0]           eng_num_d, eng_spd_d, eng_acc_d, eng_jrk_d;
    logic                   last_axis, skip_axis, advance;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        idx_d       = idx;
        gap_cnt_d   = gap_cnt;
        wd_d        = wd;
        snap_cs_d   = snap_cs;
        snap_num_d  = snap_num;
        snap_spd_d  = snap_spd;
        snap_acc_d  = snap_acc;
        snap_jrk_d  = snap_jrk;
        busy_d      = busy;
        done_d      = 1'b0;
        finish_d    = finish;
        params_d    = params;
        valid_d     = valid;
        err_d       = err;
        eng_start_d = eng.eng_start;
        eng_cs_d    = eng.eng_const_speed;
        eng_num_d   = eng.eng_num;
        eng_spd_d   = eng.eng_speed;
        eng_acc_d   = eng.eng_acc;
        eng_jrk_d   = eng.eng_jerk;
        advance     = 1'b0;
        last_axis   = (32'(idx) == N_AXES - 1);
        skip_axis   = (SKIP_ZERO != 0) && (snap_num[int'(idx)*W +: W] == '0);

        case (state)
            S_IDLE: begin
                if (start) begin
                    snap_cs_d  = const_speed;
                    snap_num_d = num;
                    snap_spd_d = speed;
                    snap_acc_d = acceleration;
                    snap_jrk_d = jerk;
                    params_d   = '0;
                    valid_d    = '0;
                    err_d      = '0;
                    finish_d   = 1'b0;
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (skip_axis) begin
                    params_d[int'(idx)*BW +: BW] = '0;
                    valid_d[idx] = 1'b1;
                    advance      = 1'b1;
                end else begin
                    eng_cs_d    = snap_cs;
                    eng_num_d   = snap_num[int'(idx)*W +: W];
                    eng_spd_d   = snap_spd[int'(idx)*W +: W];
                    eng_acc_d   = snap_acc[int'(idx)*W +: W];
                    eng_jrk_d   = snap_jrk[int'(idx)*W +: W];
                    eng_start_d = 1'b1;
                    wd_d        = '0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (eng.eng_finish) begin
                    params_d[int'(idx)*BW +: BW] = eng.eng_params;
                    valid_d[idx] = 1'b1;
                    eng_start_d  = 1'b0;
                    gap_cnt_d    = 16'(GAP);
                    state_d      = S_GAP;
                end else if (wd == WDW'(TIMEOUT - 1)) begin
                    // Watchdog expiry: the bank stays zero and valid stays low
                    err_d[idx]  = 1'b1;
                    eng_start_d = 1'b0;
                    gap_cnt_d   = 16'(GAP);
                    state_d     = S_GAP;
                end else if (wd != '1) begin
                    wd_d = wd + WDW'(1);
                end
            end
            S_GAP: begin
                // A stuck-high eng_finish holds the scheduler here
                if (gap_cnt != 16'd0) begin
                    gap_cnt_d = gap_cnt - 16'd1;
                end else if (!eng.eng_finish) begin
                    advance = 1'b1;
                end
            end
            S_DONE: begin
                done_d   = 1'b1;
                finish_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (last_axis) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx + IW'(1);
                state_d = S_LOAD;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state               <= S_IDLE;
            idx                 <= '0;
            gap_cnt             <= '0;
            wd                  <= '0;
            snap_cs             <= 1'b0;
            snap_num            <= '0;
            snap_spd            <= '0;
            snap_acc            <= '0;
            snap_jrk            <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            finish              <= 1'b0;
            params              <= '0;
            valid               <= '0;
            err                 <= '0;
            eng.eng_start       <= 1'b0;
            eng.eng_const_speed <= 1'b0;
            eng.eng_num         <= '0;
            eng.eng_speed       <= '0;
            eng.eng_acc         <= '0;
            eng.eng_jerk        <= '0;
        end else begin
            state               <= state_d;
            idx                 <= idx_d;
            gap_cnt             <= gap_cnt_d;
            wd                  <= wd_d;
            snap_cs             <= snap_cs_d;
            snap_num            <= snap_num_d;
            snap_spd            <= snap_spd_d;
            snap_acc            <= snap_acc_d;
            snap_jrk            <= snap_jrk_d;
            busy                <= busy_d;
            done                <= done_d;
            finish              <= finish_d;
            params              <= params_d;
            valid               <= valid_d;
            err                 <= err_d;
            eng.eng_start       <= eng_start_d;
            eng.eng_const_speed <= eng_cs_d;
            eng.eng_num         <= eng_num_d;
            eng.eng_speed       <= eng_spd_d;
            eng.eng_acc         <= eng_acc_d;
            eng.eng_jerk        <= eng_jrk_d;
        end
    end
endmodule

// File: tb/tb_axis_timing_scheduler.sv
// Bench for axis_timing_scheduler: request-level model plus engine models for two configurations.
module tb_axis_timing_scheduler;
    localparam int unsigned NA = 5, WA = 32, NPA = 5, GAPA = 12, TOA = 50;
    localparam int unsigned NB = 3, WB = 24, GAPB = 4;
    localparam int LAT = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int errors = 0;
    int checks = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- DUT A: 5 axes, 32-bit, skip zero, short watchdog
    logic                   start_a, cs_a;
    logic [NA*WA-1:0]       num_a, spd_a, acc_a, jrk_a;
    logic                   busy_a, done_a, fin_a;
    logic [NA*NPA*WA-1:0]   params_a;
    logic [NA-1:0]          valid_a, err_a;
    axis_timing_scheduler_if #(.W(WA), .NP(NPA)) ifa();

    axis_timing_scheduler #(.N_AXES(NA), .W(WA), .NP(NPA), .GAP(GAPA), .TIMEOUT(TOA), .SKIP_ZERO(1)) dut_a (
        .clk(clk), .reset(rst), .start(start_a), .const_speed(cs_a),
        .num(num_a), .speed(spd_a), .acceleration(acc_a), .jerk(jrk_a),
        .busy(busy_a), .done(done_a), .finish(fin_a), .params(params_a),
        .valid(valid_a), .err(err_a), .eng(ifa)
    );

    // Engine A: answers LAT cycles after launch with words num-1+p; hangs on hang_num
    logic              efin_a;
    logic [NPA*WA-1:0] eres_a;
    int                ecnt_a;
    bit                hang_en;
    logic [WA-1:0]     hang_num;
    assign ifa.eng_finish = efin_a;
    assign ifa.eng_params = eres_a;
    always @(posedge clk) begin
        if (!rst || !ifa.eng_start) begin
            efin_a <= 1'b0;
            ecnt_a <= 0;
        end else if (!efin_a && !(hang_en && ifa.eng_num == hang_num)) begin
            if (ecnt_a == LAT - 1) begin
                efin_a <= 1'b1;
                for (int p = 0; p < NPA; p++) eres_a[p*WA +: WA] <= ifa.eng_num - 32'd1 + 32'(p);
            end else begin
                ecnt_a <= ecnt_a + 1;
            end
        end
    end

    // Request-level model for DUT A, updated at each rising edge
    bit            m_busy, m_fin;
    logic [WA-1:0] e_num [NA];
    logic [WA-1:0] e_spd [NA];
    logic [WA-1:0] e_acc [NA];
    logic [WA-1:0] e_jrk [NA];
    logic [WA-1:0] e_par [NA][NPA];
    logic          e_cs;
    logic [NA-1:0] e_valid, e_err;
    int            lq[$];
    int            cyc = 0;
    int            last_fall = -1000;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst) begin
            m_busy = 1'b0;
            m_fin  = 1'b0;
            last_fall = -1000;
            lq.delete();
        end else begin
            if (m_busy && done_a) begin
                m_busy = 1'b0;
                m_fin  = 1'b1;
            end
            if (!m_busy && start_a) begin
                m_busy = 1'b1;
                m_fin  = 1'b0;
                e_cs   = cs_a;
                lq.delete();
                for (int a = 0; a < NA; a++) begin
                    e_num[a] = num_a[a*WA +: WA];
                    e_spd[a] = spd_a[a*WA +: WA];
                    e_acc[a] = acc_a[a*WA +: WA];
                    e_jrk[a] = jrk_a[a*WA +: WA];
                    e_valid[a] = 1'b0;
                    e_err[a]   = 1'b0;
                    for (int p = 0; p < NPA; p++) e_par[a][p] = '0;
                    if (e_num[a] == '0) begin
                        e_valid[a] = 1'b1;
                    end else begin
                        lq.push_back(a);
                        if (hang_en && e_num[a] == hang_num) begin
                            e_err[a] = 1'b1;
                        end else begin
                            e_valid[a] = 1'b1;
                            for (int p = 0; p < NPA; p++) e_par[a][p] = e_num[a] - 32'd1 + 32'(p);
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison of DUT A against the model
    bit            prev_es = 1'b0, prev_done = 1'b0;
    logic [WA-1:0] prev_num = '0;
    int            done_cnt = 0;
    int            n_launch = 0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (done_a) begin
                done_cnt++;
                chk(m_busy, "done_without_request", 64'(done_a), 64'(0));
                chk(!prev_done, "done_pulse_width", 64'(prev_done), 64'(0));
                chk(busy_a == 1'b0, "busy_at_done", 64'(busy_a), 64'(0));
                chk(fin_a == 1'b1, "finish_at_done", 64'(fin_a), 64'(1));
                chk(valid_a == e_valid, "valid_at_done", 64'(valid_a), 64'(e_valid));
                chk(err_a == e_err, "err_at_done", 64'(err_a), 64'(e_err));
                chk(lq.size() == 0, "launches_pending", 64'(lq.size()), 64'(0));
                for (int a = 0; a < NA; a++)
                    for (int p = 0; p < NPA; p++)
                        chk(params_a[(a*NPA+p)*WA +: WA] == e_par[a][p], "params_word",
                            64'(params_a[(a*NPA+p)*WA +: WA]), 64'(e_par[a][p]));
            end else begin
                chk(busy_a == m_busy, "busy", 64'(busy_a), 64'(m_busy));
                chk(fin_a == m_fin, "finish", 64'(fin_a), 64'(m_fin));
            end
            if (ifa.eng_start && !prev_es) begin
                n_launch++;
                chk(lq.size() != 0, "launch_expected", 64'(lq.size()), 64'(1));
                if (lq.size() != 0) begin
                    int a;
                    a = lq.pop_front();
                    chk(ifa.eng_num == e_num[a], "eng_num", 64'(ifa.eng_num), 64'(e_num[a]));
                    chk(ifa.eng_speed == e_spd[a], "eng_speed", 64'(ifa.eng_speed), 64'(e_spd[a]));
                    chk(ifa.eng_acc == e_acc[a], "eng_acc", 64'(ifa.eng_acc), 64'(e_acc[a]));
                    chk(ifa.eng_jerk == e_jrk[a], "eng_jerk", 64'(ifa.eng_jerk), 64'(e_jrk[a]));
                    chk(ifa.eng_const_speed == e_cs, "eng_const_speed", 64'(ifa.eng_const_speed), 64'(e_cs));
                    chk(cyc - last_fall >= int'(GAPA), "launch_gap", 64'(cyc - last_fall), 64'(GAPA));
                end
            end else if (ifa.eng_start && prev_es) begin
                chk(ifa.eng_num == prev_num, "eng_num_stable", 64'(ifa.eng_num), 64'(prev_num));
            end
            if (!ifa.eng_start && prev_es && m_busy) last_fall = cyc;
        end
        prev_es   = ifa.eng_start;
        prev_done = done_a;
        prev_num  = ifa.eng_num;
    end

    // ---------------- DUT B: 3 axes, 24-bit, no skipping
    logic                   start_b, cs_b;
    logic [NB*WB-1:0]       num_b, spd_b, acc_b, jrk_b;
    logic                   busy_b, done_b, fin_b;
    logic [NB*NPA*WB-1:0]   params_b;
    logic [NB-1:0]          valid_b, err_b;
    axis_timing_scheduler_if #(.W(WB), .NP(NPA)) ifb();

    axis_timing_scheduler #(.N_AXES(NB), .W(WB), .NP(NPA), .GAP(GAPB), .TIMEOUT(TOA), .SKIP_ZERO(0)) dut_b (
        .clk(clk), .reset(rst), .start(start_b), .const_speed(cs_b),
        .num(num_b), .speed(spd_b), .acceleration(acc_b), .jerk(jrk_b),
        .busy(busy_b), .done(done_b), .finish(fin_b), .params(params_b),
        .valid(valid_b), .err(err_b), .eng(ifb)
    );

    logic              efin_b;
    logic [NPA*WB-1:0] eres_b;
    int                ecnt_b;
    assign ifb.eng_finish = efin_b;
    assign ifb.eng_params = eres_b;
    always @(posedge clk) begin
        if (!rst || !ifb.eng_start) begin
            efin_b <= 1'b0;
            ecnt_b <= 0;
        end else if (!efin_b) begin
            if (ecnt_b == LAT - 1) begin
                efin_b <= 1'b1;
                for (int p = 0; p < NPA; p++) eres_b[p*WB +: WB] <= ifb.eng_num + 24'(p);
            end else begin
                ecnt_b <= ecnt_b + 1;
            end
        end
    end

    logic [WB-1:0] qb[$];
    bit pes_b = 1'b0;
    initial forever begin
        @(negedge clk);
        if (ifb.eng_start && !pes_b) qb.push_back(ifb.eng_num);
        pes_b = ifb.eng_start;
    end

    // ---------------- helpers
    task automatic wait_done_a(input int limit);
        int n = 0;
        while (!done_a && n < limit) begin @(negedge clk); n++; end
        chk(done_a == 1'b1, "done_a_timeout", 64'(n), 64'(limit));
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic set_nums_a(input bit zero);
        for (int a = 0; a < NA; a++) begin
            num_a[a*WA +: WA] = zero ? 32'd0 : 32'(a + 1);
            spd_a[a*WA +: WA] = 32'(100 + a);
            acc_a[a*WA +: WA] = 32'(200 + a);
            jrk_a[a*WA +: WA] = 32'(300 + a);
        end
    endtask

    task automatic check_plain_params_a(input string name);
        for (int a = 0; a < NA; a++)
            for (int p = 0; p < NPA; p++)
                chk(params_a[(a*NPA+p)*WA +: WA] == 32'(a + p), name,
                    64'(params_a[(a*NPA+p)*WA +: WA]), 64'(a + p));
    endtask

    initial begin
        int n, d0, l0;
        int vb [NB];
        rst = 1'b0; start_a = 1'b0; cs_a = 1'b0; hang_en = 1'b0; hang_num = '0;
        num_a = '0; spd_a = '0; acc_a = '0; jrk_a = '0;
        start_b = 1'b0; cs_b = 1'b0; num_b = '0; spd_b = '0; acc_b = '0; jrk_b = '0;
        repeat (3) @(negedge clk);

        // Reset values
        chk(busy_a == 1'b0 && done_a == 1'b0 && fin_a == 1'b0, "reset_flags", 64'({busy_a, done_a, fin_a}), 64'(0));
        chk(valid_a == '0 && err_a == '0, "reset_valid_err", 64'({valid_a, err_a}), 64'(0));
        chk(params_a == '0, "reset_params", 64'(|params_a), 64'(0));
        chk(ifa.eng_start == 1'b0 && ifa.eng_num == '0, "reset_eng", 64'(ifa.eng_num), 64'(0));
        chk(busy_b == 1'b0 && ifb.eng_start == 1'b0, "reset_b", 64'({busy_b, ifb.eng_start}), 64'(0));
        rst = 1'b1;
        @(negedge clk);

        // All axes skipped: done follows the accepting edge by N_AXES+1 edges
        set_nums_a(1'b1);
        l0 = n_launch;
        pulse_start_a();
        chk(busy_a == 1'b1, "skip_busy_after_accept", 64'(busy_a), 64'(1));
        n = 0;
        while (!done_a && n < 100) begin @(negedge clk); n++; end
        chk(n == 6, "skip_done_latency", 64'(n), 64'(6));
        chk(valid_a == 5'b11111, "skip_valid", 64'(valid_a), 64'h1f);
        chk(params_a == '0, "skip_params_zero", 64'(|params_a), 64'(0));
        chk(n_launch == l0, "skip_no_launch", 64'(n_launch), 64'(l0));
        repeat (3) @(negedge clk);

        // Normal run with engine
        set_nums_a(1'b0);
        cs_a = 1'b1;
        d0 = done_cnt;
        pulse_start_a();
        chk(ifa.eng_start == 1'b0, "eng_start_after_k", 64'(ifa.eng_start), 64'(0));
        @(negedge clk);
        chk(ifa.eng_start == 1'b1 && ifa.eng_num == 32'd1, "eng_start_after_k1",
            64'({ifa.eng_start, ifa.eng_num}), 64'({1'b1, 32'd1}));
        wait_done_a(2000);
        check_plain_params_a("run_param");
        chk(valid_a == 5'b11111 && err_a == '0, "run_valid_err", 64'({valid_a, err_a}), 64'h3e0);
        repeat (5) @(negedge clk);
        chk(fin_a == 1'b1 && busy_a == 1'b0, "run_finish_holds", 64'({fin_a, busy_a}), 64'h2);
        chk(done_cnt == d0 + 1, "run_done_once", 64'(done_cnt), 64'(d0 + 1));

        // Start while busy on axis 2 is ignored
        d0 = done_cnt;
        l0 = n_launch;
        pulse_start_a();
        n = 0;
        while (n_launch < l0 + 3 && n < 2000) begin @(negedge clk); n++; end
        chk(n_launch == l0 + 3, "reached_axis2", 64'(n_launch), 64'(l0 + 3));
        for (int a = 0; a < NA; a++) num_a[a*WA +: WA] = 32'hdead_0000 + 32'(a);
        pulse_start_a();
        set_nums_a(1'b0);
        wait_done_a(2000);
        check_plain_params_a("ignored_start_param");
        repeat (8) @(negedge clk);
        chk(done_cnt == d0 + 1, "ignored_start_done_once", 64'(done_cnt), 64'(d0 + 1));
        chk(busy_a == 1'b0, "ignored_start_no_rerun", 64'(busy_a), 64'(0));

        // Watchdog on axis 1
        hang_en = 1'b1;
        hang_num = 32'd2;
        pulse_start_a();
        wait_done_a(3000);
        chk(err_a == 5'b00010, "wd_err", 64'(err_a), 64'h02);
        chk(valid_a == 5'b11101, "wd_valid", 64'(valid_a), 64'h1d);
        chk(params_a[1*NPA*WA +: NPA*WA] == '0, "wd_bank1_zero", 64'(|params_a[1*NPA*WA +: NPA*WA]), 64'(0));
        chk(params_a[(4*NPA+4)*WA +: WA] == 32'd8, "wd_axis4_word4", 64'(params_a[(4*NPA+4)*WA +: WA]), 64'd8);
        hang_en = 1'b0;
        repeat (3) @(negedge clk);

        // Reset while waiting on axis 3
        pulse_start_a();
        n = 0;
        while (!(ifa.eng_start && ifa.eng_num == 32'd4) && n < 2000) begin @(negedge clk); n++; end
        chk(ifa.eng_start && ifa.eng_num == 32'd4, "reached_axis3", 64'(ifa.eng_num), 64'd4);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk(ifa.eng_start == 1'b0, "abort_eng_start", 64'(ifa.eng_start), 64'(0));
        chk({busy_a, done_a, fin_a} == 3'b000, "abort_flags", 64'({busy_a, done_a, fin_a}), 64'(0));
        chk(valid_a == '0 && err_a == '0, "abort_valid_err", 64'({valid_a, err_a}), 64'(0));
        chk(params_a == '0, "abort_params", 64'(|params_a), 64'(0));
        chk(ifa.eng_num == '0 && ifa.eng_speed == '0, "abort_eng_data", 64'(ifa.eng_num), 64'(0));
        @(negedge clk);
        pulse_start_a();
        wait_done_a(2000);
        check_plain_params_a("after_abort_param");
        chk(valid_a == 5'b11111, "after_abort_valid", 64'(valid_a), 64'h1f);
        repeat (3) @(negedge clk);

        // Start held high across done restarts from the following IDLE cycle
        set_nums_a(1'b1);
        d0 = done_cnt;
        start_a = 1'b1;
        @(negedge clk);
        wait_done_a(100);
        @(negedge clk);
        chk(busy_a == 1'b1 && fin_a == 1'b0, "held_start_restart", 64'({busy_a, fin_a}), 64'h2);
        start_a = 1'b0;
        @(negedge clk);
        wait_done_a(100);
        chk(done_cnt == d0 + 2, "held_start_two_done", 64'(done_cnt), 64'(d0 + 2));
        repeat (3) @(negedge clk);

        // DUT B: every axis goes through the engine, including num==0
        vb[0] = -5; vb[1] = 0; vb[2] = 7;
        for (int a = 0; a < NB; a++) begin
            num_b[a*WB +: WB] = 24'(vb[a]);
            spd_b[a*WB +: WB] = 24'(50 + a);
        end
        qb.delete();
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 2000) begin @(negedge clk); n++; end
        chk(done_b == 1'b1, "b_done_timeout", 64'(n), 64'(2000));
        chk(qb.size() == NB, "b_launch_count", 64'(qb.size()), 64'(NB));
        for (int a = 0; a < NB && a < qb.size(); a++)
            chk(qb[a] == 24'(vb[a]), "b_launch_num", 64'(qb[a]), 64'(24'(vb[a])));
        chk(valid_b == 3'b111 && err_b == '0, "b_valid_err", 64'({valid_b, err_b}), 64'h38);
        for (int a = 0; a < NB; a++)
            for (int p = 0; p < NPA; p++)
                chk(params_b[(a*NPA+p)*WB +: WB] == 24'(vb[a] + p), "b_param",
                    64'(params_b[(a*NPA+p)*WB +: WB]), 64'(24'(vb[a] + p)));
        chk(fin_b == 1'b1 && busy_b == 1'b0, "b_finish", 64'({fin_b, busy_b}), 64'h2);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
